// File: rtl/neuraedge_host_ingress_if.sv
// Flit handshake bundle between the host, the ingress stage and the NPU.
// The ingress stage is the slave; the host/NPU side (or a bench) is the master.
interface neuraedge_host_ingress_if #(
  parameter int FLIT_W = 64
);
  logic [FLIT_W-1:0] host_flit_in;
  logic              host_valid_in;
  logic              host_ready_out;
  logic [FLIT_W-1:0] npu_flit_out;
  logic              npu_valid_out;
  logic              npu_ready_in;

  modport slave (
    input  host_flit_in,
    input  host_valid_in,
    input  npu_ready_in,
    output host_ready_out,
    output npu_flit_out,
    output npu_valid_out
  );

  modport master (
    output host_flit_in,
    output host_valid_in,
    output npu_ready_in,
    input  host_ready_out,
    input  npu_flit_out,
    input  npu_valid_out
  );
endinterface

// File: rtl/neuraedge_host_ingress.sv
// Host ingress: framing check, malformed-flit drop/count, first-word fall-through FIFO to the NPU.
// Defining NEURAEDGE_PKT_CNT_EN adds the pkt_count port and its completed-packet counter.
module neuraedge_host_ingress #(
  parameter int FLIT_W = 64,
  parameter int DEPTH  = 8,
  parameter int ERR_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  neuraedge_host_ingress_if.slave bus,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic [ERR_W-1:0]        err_count,
  output logic                    err_pulse
`ifdef NEURAEDGE_PKT_CNT_EN
  ,
  output logic [31:0]             pkt_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0]    DEPTH_LVL = PW'(DEPTH);
  localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

  typedef enum logic [1:0] {
    FT_BODY   = 2'b00,
    FT_TAIL   = 2'b01,
    FT_HEAD   = 2'b10,
    FT_SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } frame_state_e;

  frame_state_e      state_r;
  frame_state_e      state_next_s;
  flit_type_e        in_type_s;
  logic [FLIT_W-1:0] mem_r [DEPTH];
  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [PW-1:0]     level_r;
  logic [PW-1:0]     level_next_s;
  logic              ready_r;
  logic              err_pulse_r;
  logic [ERR_W-1:0]  err_count_r;
  logic              full_s;
  logic              empty_s;
  logic              accept_s;
  logic              frame_ok_s;
  logic              push_s;
  logic              drop_s;
  logic              pop_s;

  assign in_type_s = flit_type_e'(bus.host_flit_in[FLIT_W-1 -: 2]);

  // Extra wrap bit on each pointer tells full (MSBs differ) from empty (all equal).
  assign full_s   = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty_s  = (wr_ptr_r == rd_ptr_r);
  assign accept_s = bus.host_valid_in & ready_r;
  assign push_s   = accept_s & frame_ok_s & ~full_s;
  assign drop_s   = accept_s & ~frame_ok_s;
  assign pop_s    = ~empty_s & bus.npu_ready_in;

  // Framing decision for the flit currently offered by the host.
  always_comb begin
    frame_ok_s   = 1'b0;
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        case (in_type_s)
          FT_HEAD: begin
            frame_ok_s   = 1'b1;
            state_next_s = ST_IN_PKT;
          end
          FT_SINGLE: frame_ok_s = 1'b1;
          default:   frame_ok_s = 1'b0;
        endcase
      end
      ST_IN_PKT: begin
        case (in_type_s)
          FT_BODY: frame_ok_s = 1'b1;
          FT_TAIL: begin
            frame_ok_s   = 1'b1;
            state_next_s = ST_IDLE;
          end
          default: frame_ok_s = 1'b0;
        endcase
      end
      default: begin
        frame_ok_s   = 1'b0;
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Occupancy after this cycle's push/pop.
  always_comb begin
    level_next_s = level_r;
    case ({push_s, pop_s})
      2'b10:   level_next_s = level_r + {{(PW-1){1'b0}}, 1'b1};
      2'b01:   level_next_s = level_r - {{(PW-1){1'b0}}, 1'b1};
      default: level_next_s = level_r;
    endcase
  end

  // Framing FSM with registered error pulse and saturating error counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      err_pulse_r <= 1'b0;
      err_count_r <= {ERR_W{1'b0}};
    end else begin
      err_pulse_r <= drop_s;
      if (accept_s) begin
        state_r <= state_next_s;
      end else begin
        state_r <= state_r;
      end
      if (drop_s && (err_count_r != ERR_MAX)) begin
        err_count_r <= err_count_r + {{(ERR_W-1){1'b0}}, 1'b1};
      end else begin
        err_count_r <= err_count_r;
      end
    end
  end

  // FIFO storage and pointers; pointers wrap modulo 2*DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {FLIT_W{1'b0}};
      end
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= bus.host_flit_in;
        wr_ptr_r                <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      end
    end
  end

  // Registered level and host ready; ready stays low through reset and one edge after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_r <= {PW{1'b0}};
      ready_r <= 1'b0;
    end else begin
      level_r <= level_next_s;
      ready_r <= (level_next_s != DEPTH_LVL);
    end
  end

`ifdef NEURAEDGE_PKT_CNT_EN
  logic [31:0] pkt_count_r;

  // Count popped TAIL/SINGLE flits; both types have the low type bit set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count_r <= 32'd0;
    end else if (pop_s && bus.npu_flit_out[FLIT_W-2]) begin
      pkt_count_r <= pkt_count_r + 32'd1;
    end else begin
      pkt_count_r <= pkt_count_r;
    end
  end

  assign pkt_count = pkt_count_r;
`endif

  assign bus.host_ready_out = ready_r;
  assign bus.npu_valid_out  = ~empty_s;
  assign bus.npu_flit_out   = mem_r[rd_ptr_r[AW-1:0]];
  assign fifo_level         = level_r;
  assign err_count          = err_count_r;
  assign err_pulse          = err_pulse_r;

endmodule

// File: tb/tb_neuraedge_host_ingress.sv
// Scoreboard bench for neuraedge_host_ingress: directed scenarios plus randomized traffic.
module tb_neuraedge_host_ingress;

  logic        clk;
  logic        rst_n;
  logic [3:0]  fifo_level;
  logic [15:0] err_count;
  logic        err_pulse;
`ifdef NEURAEDGE_PKT_CNT_EN
  logic [31:0] pkt_count;
`endif

  neuraedge_host_ingress_if #(.FLIT_W(64)) bus ();

  neuraedge_host_ingress #(.FLIT_W(64), .DEPTH(8), .ERR_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .fifo_level (fifo_level),
    .err_count  (err_count),
    .err_pulse  (err_pulse)
`ifdef NEURAEDGE_PKT_CNT_EN
    ,
    .pkt_count  (pkt_count)
`endif
  );

  localparam logic [1:0] T_BODY = 2'b00, T_TAIL = 2'b01, T_HEAD = 2'b10, T_SINGLE = 2'b11;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: flits expected to come out, in order
  logic [63:0] exp_q[$];
  bit          in_pkt    = 0;
  int          exp_err   = 0;
  bit          exp_pulse = 0;
  bit          ready_ok  = 0;
  longint      exp_pkt   = 0;

  // Handshakes observed by the monitor, consumed by the model at the next edge
  bit          smp_acc  = 0;
  logic [63:0] smp_flit = '0;
  bit          smp_pop  = 0;
  logic [1:0]  smp_pop_type = 2'b00;
  bit          rand_ready = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mk(input logic [1:0] t);
    logic [63:0] r;
    r = {$urandom, $urandom};
    r[63:62] = t;
    return r;
  endfunction

  // Model: apply the framing rules to each accepted flit at the clock edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      in_pkt    = 0;
      exp_err   = 0;
      exp_pulse = 0;
      ready_ok  = 0;
      exp_pkt   = 0;
    end else begin
      ready_ok  = 1;
      exp_pulse = 0;
      if (smp_pop && smp_pop_type[0]) exp_pkt = (exp_pkt + 1) % 64'h1_0000_0000;
      if (smp_acc) begin
        logic [1:0] t;
        bit ok;
        t  = smp_flit[63:62];
        ok = in_pkt ? (t == T_BODY || t == T_TAIL) : (t == T_HEAD || t == T_SINGLE);
        if (ok) begin
          exp_q.push_back(smp_flit);
          if (t == T_HEAD) in_pkt = 1;
          if (t == T_TAIL) in_pkt = 0;
        end else begin
          exp_pulse = 1;
          if (exp_err < 65535) exp_err++;
        end
      end
    end
  end

  // Monitor: compare DUT outputs mid-cycle and pop the scoreboard on egress handshakes.
  always @(negedge clk) begin
    smp_acc = 0;
    smp_pop = 0;
    if (!rst_n) begin
      check("rst_npu_valid", {63'd0, bus.npu_valid_out}, 64'd0);
      check("rst_fifo_level", {60'd0, fifo_level}, 64'd0);
      check("rst_err_count", {48'd0, err_count}, 64'd0);
      check("rst_host_ready", {63'd0, bus.host_ready_out}, 64'd0);
    end else begin
      check("npu_valid", {63'd0, bus.npu_valid_out}, {63'd0, exp_q.size() != 0});
      check("fifo_level", {60'd0, fifo_level}, 64'(exp_q.size()));
      check("host_ready", {63'd0, bus.host_ready_out}, {63'd0, ready_ok && exp_q.size() != 8});
      check("err_pulse", {63'd0, err_pulse}, {63'd0, exp_pulse});
      check("err_count", {48'd0, err_count}, 64'(exp_err));
`ifdef NEURAEDGE_PKT_CNT_EN
      check("pkt_count", {32'd0, pkt_count}, 64'(exp_pkt));
`endif
      if (bus.npu_valid_out && exp_q.size() != 0) begin
        check("npu_flit", bus.npu_flit_out, exp_q[0]);
        if (bus.npu_ready_in) begin
          void'(exp_q.pop_front());
          smp_pop      = 1;
          smp_pop_type = bus.npu_flit_out[63:62];
        end
      end
      smp_acc  = bus.host_valid_in && bus.host_ready_out;
      smp_flit = bus.host_flit_in;
    end
  end

  // Random egress backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) bus.npu_ready_in = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one flit and hold it until the handshake completes (bounded wait).
  task automatic send(input logic [63:0] f);
    bit done;
    done = 0;
    bus.host_flit_in  = f;
    bus.host_valid_in = 1'b1;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      if (bus.host_ready_out) done = 1;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: host_ready_out stuck at 0, expected 1 (t=%0t)", $time);
    end
    @(posedge clk);
    #1;
    bus.host_valid_in = 1'b0;
  endtask

  initial begin
    logic [63:0] f9;
    rst_n             = 1'b0;
    bus.host_valid_in = 1'b0;
    bus.host_flit_in  = 64'd0;
    bus.npu_ready_in  = 1'b0;
    #2;
    check("init_npu_flit", bus.npu_flit_out, 64'd0);
    check("init_err_pulse", {63'd0, err_pulse}, 64'd0);
    idle(3);
    rst_n = 1'b1;
    idle(1);

    // 1: single flit, one-cycle latency
    bus.npu_ready_in = 1'b1;
    send(64'hC000_0000_0000_00AA);
    check("t1_valid", {63'd0, bus.npu_valid_out}, 64'd1);
    check("t1_flit", bus.npu_flit_out, 64'hC000_0000_0000_00AA);
    idle(2);
    check("t1_level", {60'd0, fifo_level}, 64'd0);

    // 2: full packet held then drained in order
    bus.npu_ready_in = 1'b0;
    send(mk(T_HEAD));
    send(mk(T_BODY));
    send(mk(T_BODY));
    send(mk(T_TAIL));
    idle(1);
    check("t2_level", {60'd0, fifo_level}, 64'd4);
    bus.npu_ready_in = 1'b1;
    idle(6);
`ifdef NEURAEDGE_PKT_CNT_EN
    check("t2_pkt_count", {32'd0, pkt_count}, 64'd2);
`endif

    // 3: fill to DEPTH, ninth flit held, one pop reopens ready
    bus.npu_ready_in = 1'b0;
    for (int i = 0; i < 8; i++) send(mk(T_SINGLE));
    check("t3_ready_full", {63'd0, bus.host_ready_out}, 64'd0);
    f9 = mk(T_SINGLE);
    bus.host_flit_in  = f9;
    bus.host_valid_in = 1'b1;
    idle(3);
    check("t3_level_held", {60'd0, fifo_level}, 64'd8);
    bus.npu_ready_in = 1'b1;
    idle(1);
    bus.npu_ready_in = 1'b0;
    check("t3_ready_reopen", {63'd0, bus.host_ready_out}, 64'd1);
    send(f9);
    bus.npu_ready_in = 1'b1;
    idle(12);

    // 4: framing errors
    bus.npu_ready_in = 1'b0;
    send(mk(T_BODY));
    send(mk(T_HEAD));
    send(mk(T_HEAD));
    send(mk(T_TAIL));
    idle(2);
    check("t4_level", {60'd0, fifo_level}, 64'd2);
    check("t4_err_count", {48'd0, err_count}, 64'd2);
    bus.npu_ready_in = 1'b1;
    idle(4);

    // 5: continuous streaming through pointer wrap
    for (int i = 0; i < 100; i++) send(mk(T_SINGLE));
    idle(3);

    // 6: reset mid-packet
    bus.npu_ready_in = 1'b0;
    send(mk(T_HEAD));
    for (int i = 0; i < 4; i++) send(mk(T_BODY));
    check("t6_level_pre", {60'd0, fifo_level}, 64'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", {63'd0, bus.npu_valid_out}, 64'd0);
    check("t6_rst_flit", bus.npu_flit_out, 64'd0);
    check("t6_rst_level", {60'd0, fifo_level}, 64'd0);
    check("t6_rst_err", {48'd0, err_count}, 64'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    send(mk(T_BODY));
    idle(2);
    check("t6_body_dropped", {48'd0, err_count}, 64'd1);
    check("t6_level_post", {60'd0, fifo_level}, 64'd0);

    // Randomized traffic with random backpressure
    rand_ready = 1;
    for (int i = 0; i < 400; i++) begin
      idle($urandom_range(0, 2));
      send(mk(2'($urandom_range(0, 3))));
    end
    rand_ready       = 0;
    bus.npu_ready_in = 1'b1;
    idle(20);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    check("drain_valid", {63'd0, bus.npu_valid_out}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
